// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, writeback entry type and grant encoding for the RF writeback arbiter
package rf_wb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MEM} gnt_t;
endpackage

// File: rtl/rf_wb_if.sv
// rf_wb_if: writeback request, RF write port and hazard-check signals of the RF writeback arbiter
interface rf_wb_if #(parameter int AW = 5, parameter int DW = 32);
  logic alu_req, alu_ack, mem_req, mem_ack, RegWrite, rs_busy, rt_busy, idle;
  logic [AW-1:0] alu_addr, mem_addr, RDaddr, RSaddr, RTaddr;
  logic [DW-1:0] alu_data, mem_data, RDdata;
  modport slave (
    input alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data, RSaddr, RTaddr,
    output alu_ack, mem_ack, RegWrite, RDaddr, RDdata, rs_busy, rt_busy, idle
  );
  modport master (
    output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data, RSaddr, RTaddr,
    input alu_ack, mem_ack, RegWrite, RDaddr, RDdata, rs_busy, rt_busy, idle
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: QDEPTH-entry FIFO with push/pop/full/empty and head-of-queue output
module rf_wb_queue #(
  parameter int QDEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int A = $clog2(QDEPTH);
  logic [W-1:0] mem [QDEPTH];
  logic [A:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == (rp ^ {1'b1, {A{1'b0}}});
  assign head = mem[rp[A-1:0]];
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[A-1:0]] <= din;
        wp <= wp + {{A{1'b0}}, 1'b1};
      end
      if (pop && !empty) rp <= rp + {{A{1'b0}}, 1'b1};
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the RF write port between ALU and load writeback, with pending-write scoreboard; RF_WB_STATS_EN adds conflict_cnt
module rf_wb_arbiter #(
  parameter int QDEPTH = 2,
  parameter int AW = rf_wb_pkg::AW,
  parameter int DW = rf_wb_pkg::DW
) (
  input logic clk,
  input logic rst,
  rf_wb_if.slave bus
`ifdef RF_WB_STATS_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);
  import rf_wb_pkg::*;
  localparam int W = AW + DW;
  localparam int CW = $clog2(2 * QDEPTH + 2);
  logic alu_full, alu_empty, mem_full, mem_empty, alu_push, mem_push, last_mem, g_wr, both;
  logic [W-1:0] alu_head, mem_head, g_head;
  logic [CW-1:0] cnt [2**AW];
  gnt_t gnt;
  assign alu_push = bus.alu_req && !alu_full;
  assign mem_push = bus.mem_req && !mem_full;
  assign bus.alu_ack = !alu_full;
  assign bus.mem_ack = !mem_full;
  assign bus.idle = alu_empty && mem_empty && !bus.RegWrite;
  assign bus.rs_busy = bus.RSaddr != AW'(REG_ZERO) && cnt[bus.RSaddr] != '0;
  assign bus.rt_busy = bus.RTaddr != AW'(REG_ZERO) && cnt[bus.RTaddr] != '0;
  rf_wb_queue #(.QDEPTH(QDEPTH), .W(W)) u_alu_q (
    .clk(clk), .rst(rst), .push(alu_push), .din({bus.alu_addr, bus.alu_data}),
    .pop(gnt == GNT_ALU), .full(alu_full), .empty(alu_empty), .head(alu_head)
  );
  rf_wb_queue #(.QDEPTH(QDEPTH), .W(W)) u_mem_q (
    .clk(clk), .rst(rst), .push(mem_push), .din({bus.mem_addr, bus.mem_data}),
    .pop(gnt == GNT_MEM), .full(mem_full), .empty(mem_empty), .head(mem_head)
  );
  always_comb begin
    both = !alu_empty && !mem_empty;
    gnt = both ? (last_mem ? GNT_ALU : GNT_MEM) : !alu_empty ? GNT_ALU : !mem_empty ? GNT_MEM : GNT_NONE;
    g_head = gnt == GNT_MEM ? mem_head : alu_head;
    g_wr = gnt != GNT_NONE && g_head[W-1:DW] != AW'(REG_ZERO);
  end
  always_ff @(posedge clk)
    if (rst) begin
      last_mem <= 1'b0;
      bus.RegWrite <= 1'b0;
      bus.RDaddr <= '0;
      bus.RDdata <= '0;
    end else begin
      if (gnt != GNT_NONE) last_mem <= gnt == GNT_MEM;
      bus.RegWrite <= g_wr;
      if (g_wr) {bus.RDaddr, bus.RDdata} <= g_head;
    end
  // an entry counts as pending from enqueue until its RegWrite cycle retires
  always_ff @(posedge clk)
    for (int r = 0; r < 2**AW; r++)
      if (rst) cnt[r] <= '0;
      else cnt[r] <= cnt[r]
        + CW'(alu_push && bus.alu_addr == AW'(r) && r != 0)
        + CW'(mem_push && bus.mem_addr == AW'(r) && r != 0)
        - CW'(bus.RegWrite && bus.RDaddr == AW'(r));
`ifdef RF_WB_STATS_EN
  always_ff @(posedge clk)
    if (rst) conflict_cnt <= '0;
    else if (both && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
`endif
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/RDaddr/RDdata) between two writeback requesters: ALU writeback (alu_*) and memory-load writeback (mem_*).
- Each requester gets a small queue. Grants alternate round-robin.
- A per-register pending scoreboard lets decode stall on RS/RT read-after-write hazards.
- Sits between the EX/MEM writeback sources and RF.

Parameters:
- QDEPTH, 2, entries per requester queue (power of 2, >=2).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- alu_req  in  1  ALU write request valid
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ack  out  1  ALU request accepted this cycle (= ALU queue not full)
- mem_req  in  1  load write request valid
- mem_addr  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ack  out  1  load request accepted this cycle (= mem queue not full)
- RegWrite  out  1  RF write enable (registered)
- RDaddr  out  AW  RF write address (registered)
- RDdata  out  DW  RF write data (registered)
- RSaddr  in  AW  decode-stage RS address for hazard check
- RTaddr  in  AW  decode-stage RT address for hazard check
- rs_busy  out  1  write to RSaddr pending (combinational)
- rt_busy  out  1  write to RTaddr pending (combinational)
- idle  out  1  both queues empty and RegWrite=0

Behaviour:
- Reset (rst=1 at clk edge), including mid-operation:
  - queues flushed, scoreboard zeroed, round-robin pointer set to ALU.
  - RegWrite=0, RDaddr=0, RDdata=0.
  - alu_ack=mem_ack=1 the cycle after reset.
- Accept: req&&ack enqueues {addr,data} at the edge.
  - ack depends only on queue fullness; no pass-through when full.
  - Enqueue and dequeue in the same cycle are legal when the queue is not full.
  - req while ack=0 is ignored; the requester must hold.
- Arbitration, each cycle:
  - If exactly one queue head is valid, that head is granted.
  - If both are valid, the non-last-granted side wins and the pointer flips.
  - The granted head dequeues at the edge. RegWrite/RDaddr/RDdata reflect it the following cycle; latency from enqueue to RegWrite is at least 2 cycles.
  - With no grant, RegWrite=0 and RDaddr/RDdata hold their previous values.
- Address 0 ($zero): accepted and queued normally, but when granted RegWrite stays 0 (the slot is consumed). It is never counted in the scoreboard.
- Scoreboard:
  - Per-register counter, width $clog2(2*QDEPTH+2).
  - Increments on enqueue and decrements when the corresponding RegWrite cycle completes. Enqueue plus retire on the same register in the same cycle leaves the count unchanged. Both queues enqueueing the same register in the same cycle adds 2.
  - rs_busy = (RSaddr!=0) && count[RSaddr]!=0; rt_busy likewise.
  - A register being written this cycle (RegWrite=1, RDaddr match) still reads busy. RF latches at this edge, so busy drops the next cycle.
- Ordering: FIFO order is preserved per requester. Cross-requester order for the same register is not tracked; decode must stall on busy before issuing a second writer.
- Counter saturation cannot occur by construction (max 2*QDEPTH+1 pending).

Optional Feature:
- Macro RF_WB_STATS_EN.
- Defined: adds output conflict_cnt [15:0], counting cycles with both heads valid. It saturates at 16'hFFFF and is cleared by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rf_wb_pkg: AW/DW defaults, wb_entry_t {addr,data}, REG_ZERO constant, grant-select enum {GNT_NONE, GNT_ALU, GNT_MEM}.
- One sub-module, rf_wb_queue: parameterised QDEPTH FIFO with push/pop/full/empty/head. It is instantiated twice.

Test Plan:
- Reset, then alu_req addr=5 data=50 for one cycle:
  - alu_ack=1.
  - Two cycles later RegWrite=1, RDaddr=5, RDdata=50.
  - rs_busy=1 with RSaddr=5 until the cycle after the write.
- Simultaneous alu (addr 3, data 30) and mem (addr 4, data 40) every cycle for 6 cycles:
  - RegWrite alternates ALU/MEM starting with MEM (pointer=ALU after reset).
  - alu_ack/mem_ack drop to 0 once queues hold QDEPTH.
  - No lost entries: 6 writes of each total, at most one write per cycle.
- Write to addr 0 with data 99:
  - alu_ack=1 and RegWrite stays 0 on the grant slot.
  - rs_busy=0 for RSaddr=0.
  - idle returns to 1.
- Fill ALU queue (addrs 1,2), then assert rst mid-drain:
  - Next cycle RegWrite=0, alu_ack=1, idle=1, all busy flags 0.
  - Flushed writes never appear on RegWrite.
- Two ALU writes to addr 7 back-to-back (data 70, 71):
  - RDdata 70 then 71 in order.
  - rt_busy with RTaddr=7 stays 1 until the cycle after the second write.
- RF_WB_STATS_EN defined, both heads valid for 4 cycles: conflict_cnt=4. With the macro undefined, the build has no conflict_cnt port.
